// File: rtl/noc_output_arbiter_if.sv
// Handshake bundle between the input ports, the downstream credit path and one
// router output arbiter.
interface noc_output_arbiter_if #(
  parameter int NUM_IN       = 5,
  parameter int CREDIT_DEPTH = 4
);
  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CW = $clog2(CREDIT_DEPTH + 1);

  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] head;
  logic [NUM_IN-1:0] tail;
  logic              credit_return;
  logic [NUM_IN-1:0] grant;
  logic              xfer;
  logic [IW-1:0]     grant_idx;
  logic              locked;
  logic [CW-1:0]     credit_cnt;
  logic              credit_err;

  modport master (
    output req, head, tail, credit_return,
    input  grant, xfer, grant_idx, locked, credit_cnt, credit_err
  );

  modport slave (
    input  req, head, tail, credit_return,
    output grant, xfer, grant_idx, locked, credit_cnt, credit_err
  );
endinterface

// File: rtl/noc_output_arbiter.sv
// Wormhole round-robin arbiter for one NoC router output port. Whole packets are
// granted, and a flit is granted only when the downstream buffer has a free slot.
module noc_output_arbiter #(
  parameter int NUM_IN       = 5,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic                 noc_clk,
  input  logic                 noc_rst_n,
  noc_output_arbiter_if.slave  bus
);
  localparam int          IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int          CW = $clog2(CREDIT_DEPTH + 1);
  localparam int unsigned N  = NUM_IN;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic              err_q, err_d;

  logic [NUM_IN-1:0] cand;
  logic [NUM_IN-1:0] grant_c;
  logic              found;
  logic [IW-1:0]     win;
  logic              credit_ok;
  logic              xfer_c;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (32'(i) == N - 1) ? '0 : i + 1'b1;
  endfunction

  // First head candidate at or above rr_ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    cand  = bus.req & bus.head;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && cand[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  assign credit_ok = (credit_q != '0);

  // Grant is forced low while reset is asserted so outputs are quiet immediately.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    grant_c  = '0;
    case (state_q)
      IDLE: begin
        if (found && credit_ok && noc_rst_n) begin
          grant_c[win] = 1'b1;
          gidx_d       = win;
          if (bus.tail[win]) begin
            rr_ptr_d = wrap_inc(win);
          end else begin
            state_d = LOCKED;
            owner_d = win;
          end
        end
      end
      LOCKED: begin
        if (bus.req[owner_q] && credit_ok && noc_rst_n) begin
          grant_c[owner_q] = 1'b1;
          gidx_d           = owner_q;
          if (bus.tail[owner_q]) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_inc(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign xfer_c = |grant_c;

  // Overflow only when a credit arrives at full count with no flit leaving.
  always_comb begin
    credit_d = credit_q;
    err_d    = 1'b0;
    if (xfer_c && !bus.credit_return) begin
      credit_d = credit_q - 1'b1;
    end else if (!xfer_c && bus.credit_return) begin
      if (credit_q == CW'(CREDIT_DEPTH)) err_d = 1'b1;
      else                               credit_d = credit_q + 1'b1;
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      credit_q <= CW'(CREDIT_DEPTH);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign bus.grant      = grant_c;
  assign bus.xfer       = xfer_c;
  assign bus.grant_idx  = xfer_c ? gidx_d : gidx_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.credit_cnt = credit_q;
  assign bus.credit_err = err_q;
endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed vector bench for noc_output_arbiter with NUM_IN=5, CREDIT_DEPTH=4.
module tb_noc_output_arbiter;
  logic noc_clk;
  logic noc_rst_n;

  noc_output_arbiter_if #(.NUM_IN(5), .CREDIT_DEPTH(4)) bus ();

  noc_output_arbiter #(.NUM_IN(5), .CREDIT_DEPTH(4)) dut (
    .noc_clk   (noc_clk),
    .noc_rst_n (noc_rst_n),
    .bus       (bus)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  typedef struct {
    logic [4:0] req;
    logic [4:0] head;
    logic [4:0] tail;
    logic       cr;
    logic [4:0] grant;
    logic [2:0] gidx;
    logic       locked;
    logic [2:0] cnt;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   passes;

  task automatic add(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t,
                     input logic c, input logic [4:0] g, input logic [2:0] gi,
                     input logic lk, input logic [2:0] cnt, input logic e);
    vec_t v;
    v.req = r; v.head = h; v.tail = t; v.cr = c;
    v.grant = g; v.gidx = gi; v.locked = lk; v.cnt = cnt; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t,
                       input logic c);
    bus.req = r; bus.head = h; bus.tail = t; bus.credit_return = c;
  endtask

  task automatic check(input string name, input logic [4:0] g, input logic [2:0] gi,
                       input logic lk, input logic [2:0] cnt, input logic e);
    logic [13:0] act, exp;
    act = {bus.grant, bus.xfer, bus.grant_idx, bus.locked, bus.credit_cnt, bus.credit_err};
    exp = {g, |g, gi, lk, cnt, e};
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got grant=%b xfer=%b idx=%0d locked=%b cnt=%0d err=%b, want grant=%b xfer=%b idx=%0d locked=%b cnt=%0d err=%b",
                  name, bus.grant, bus.xfer, bus.grant_idx, bus.locked, bus.credit_cnt,
                  bus.credit_err, g, |g, gi, lk, cnt, e);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    //   req      head     tail     cr    grant    idx lk cnt err
    add(5'b00100, 5'b00100, 5'b00100, 1'b0, 5'b00100, 2, 0, 4, 0); // first head on input 2
    add(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 2, 0, 3, 0);
    add(5'b01010, 5'b01010, 5'b01010, 1'b1, 5'b01000, 3, 0, 4, 0); // round robin 3,1,3,1
    add(5'b01010, 5'b01010, 5'b01010, 1'b1, 5'b00010, 1, 0, 4, 0);
    add(5'b01010, 5'b01010, 5'b01010, 1'b1, 5'b01000, 3, 0, 4, 0);
    add(5'b01010, 5'b01010, 5'b01010, 1'b1, 5'b00010, 1, 0, 4, 0);
    add(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1, 0, 4, 0); // overflow credit
    add(5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1, 0, 4, 1);
    add(5'b10000, 5'b10000, 5'b10000, 1'b1, 5'b10000, 4, 0, 4, 0); // err cleared; rr -> 0
    add(5'b00101, 5'b00101, 5'b00100, 1'b1, 5'b00001, 0, 0, 4, 0); // wormhole head 0
    add(5'b00101, 5'b00100, 5'b00100, 1'b1, 5'b00001, 0, 1, 4, 0);
    add(5'b00101, 5'b00100, 5'b00101, 1'b1, 5'b00001, 0, 1, 4, 0);
    add(5'b00100, 5'b00100, 5'b00100, 1'b1, 5'b00100, 2, 0, 4, 0); // 2 wins right after tail
    add(5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 2, 0, 4, 0);
    add(5'b10000, 5'b10000, 5'b00000, 1'b0, 5'b10000, 4, 0, 4, 0); // 6-flit packet on 4
    add(5'b10000, 5'b00000, 5'b00000, 1'b0, 5'b10000, 4, 1, 3, 0);
    add(5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 4, 1, 2, 0); // bubble
    add(5'b10000, 5'b00000, 5'b00000, 1'b0, 5'b10000, 4, 1, 2, 0);
    add(5'b10000, 5'b00000, 5'b00000, 1'b0, 5'b10000, 4, 1, 1, 0);
    add(5'b10000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 4, 1, 0, 0); // credit stall
    add(5'b10000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 4, 1, 0, 0);
    add(5'b10000, 5'b00000, 5'b00000, 1'b0, 5'b10000, 4, 1, 1, 0);
    add(5'b10000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 4, 1, 0, 0);
    add(5'b10000, 5'b00000, 5'b10000, 1'b1, 5'b00000, 4, 1, 0, 0);
    add(5'b10000, 5'b00000, 5'b10000, 1'b0, 5'b10000, 4, 1, 1, 0); // tail flit
    add(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 4, 0, 0, 0);
    add(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 4, 0, 1, 0);
    add(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 4, 0, 2, 0);
    add(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 4, 0, 3, 0);
    add(5'b00010, 5'b00000, 5'b00000, 1'b0, 5'b00000, 4, 0, 4, 0); // non-head ignored in IDLE

    noc_rst_n = 1'b0;
    drive(5'($urandom), 5'($urandom), 5'($urandom), 1'b0);
    #12;
    check("reset_hold", 5'b00000, 0, 0, 4, 0);

    foreach (vecs[i]) begin
      @(negedge noc_clk);
      noc_rst_n = 1'b1;
      drive(vecs[i].req, vecs[i].head, vecs[i].tail, vecs[i].cr);
      #1;
      check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].gidx, vecs[i].locked,
            vecs[i].cnt, vecs[i].err);
    end

    // Reset in the middle of a packet owned by input 1.
    @(negedge noc_clk);
    drive(5'b00010, 5'b00010, 5'b00000, 1'b0);
    #1 check("mid_head", 5'b00010, 1, 0, 4, 0);
    @(negedge noc_clk);
    drive(5'b00010, 5'b00000, 5'b00000, 1'b0);
    #1 check("mid_body1", 5'b00010, 1, 1, 3, 0);
    @(negedge noc_clk);
    #1 check("mid_body2", 5'b00010, 1, 1, 2, 0);
    #1 noc_rst_n = 1'b0;
    #1 check("mid_reset", 5'b00000, 0, 0, 4, 0);
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    drive(5'b01010, 5'b01000, 5'b01000, 1'b0);
    #1 check("post_reset_head3", 5'b01000, 3, 0, 4, 0);
    @(negedge noc_clk);
    drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
    #1 check("post_reset_idle", 5'b00000, 3, 0, 3, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
